// File: rtl/vga_pkg.sv
// Shared constants, state encoding and address helper for the VGA frame-buffer
// arbiter: 800x600 timing, 8 pixels of 3-bit RGB packed per 24-bit word.
package vga_pkg;

    localparam int unsigned H_VISIBLE = 800;
    localparam int unsigned H_FRONT   = 56;
    localparam int unsigned H_SYNC    = 120;
    localparam int unsigned H_BACK    = 64;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_VISIBLE = 600;
    localparam int unsigned V_FRONT   = 37;
    localparam int unsigned V_SYNC    = 6;
    localparam int unsigned V_BACK    = 23;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned PIX_PER_WORD   = 8;
    localparam int unsigned WORDS_PER_LINE = H_VISIBLE / PIX_PER_WORD;

    localparam int unsigned LINE_W = 10;
    localparam int unsigned MEM_AW = 16;
    localparam int unsigned DATA_W = 24;
    localparam int unsigned LB_AW  = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // line * 100 as shift-and-add; 599*100+99 still fits in 16 bits
    function automatic logic [MEM_AW-1:0] line_base(input logic [LINE_W-1:0] line);
        logic [MEM_AW-1:0] l;
        l = MEM_AW'(line);
        return (l << 6) + (l << 5) + (l << 2);
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Drawing-engine write port, shared-memory port and line-buffer write port.
interface vga_fb_arbiter_if;
    import vga_pkg::*;

    logic              wr_req;
    logic [MEM_AW-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              lb_we;
    logic              lb_bank;
    logic [LB_AW-1:0]  lb_addr;
    logic [DATA_W-1:0] lb_wdata;

    modport master (
        input  wr_req, wr_addr, wr_data, mem_rdata,
        output wr_ack, mem_req, mem_we, mem_addr, mem_wdata,
        output lb_we, lb_bank, lb_addr, lb_wdata
    );

    modport slave (
        output wr_req, wr_addr, wr_data, mem_rdata,
        input  wr_ack, mem_req, mem_we, mem_addr, mem_wdata,
        input  lb_we, lb_bank, lb_addr, lb_wdata
    );

endinterface

// File: rtl/vga_rd_pipe.sv
// Tracks outstanding reads for MEM_LAT cycles so each returning word is
// written to the line buffer at its own index.
module vga_rd_pipe
    import vga_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             in_valid,
    input  logic [LB_AW-1:0] in_idx,
    input  logic             in_last,
    output logic             lb_we,
    output logic [LB_AW-1:0] lb_addr,
    output logic             done
);

    logic [MEM_LAT-1:0] vld_q;
    logic [MEM_LAT-1:0] last_q;
    logic [LB_AW-1:0]   idx_q [MEM_LAT];

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            vld_q  <= '0;
            last_q <= '0;
            for (int i = 0; i < int'(MEM_LAT); i++) idx_q[i] <= '0;
        end else begin
            vld_q[0]  <= in_valid;
            last_q[0] <= in_valid & in_last;
            idx_q[0]  <= in_idx;
            for (int i = 1; i < int'(MEM_LAT); i++) begin
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
                idx_q[i]  <= idx_q[i-1];
            end
        end
    end

    assign lb_we   = vld_q[MEM_LAT-1];
    assign lb_addr = idx_q[MEM_LAT-1];
    assign done    = vld_q[MEM_LAT-1] & last_q[MEM_LAT-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one memory port between line prefetch reads and drawing-engine
// writes; fetch has priority, with a write slot after every FAIR reads.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned WORDS_PER_LINE = vga_pkg::WORDS_PER_LINE,
    parameter int unsigned MEM_LAT        = 2,
    parameter int unsigned FAIR           = 8
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              fetch_req,
    input  logic [LINE_W-1:0] fetch_line,
    input  logic              err_clr,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic              fetch_err,
    vga_fb_arbiter_if.master  bus
);

    localparam int unsigned      RUN_W    = $clog2(FAIR + 1);
    localparam logic [LB_AW-1:0] LAST_IDX = LB_AW'(WORDS_PER_LINE - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(FAIR);

    state_t            state_q, state_n;
    logic [MEM_AW-1:0] base_q, base_n;
    logic [LB_AW-1:0]  rd_idx_q, rd_idx_n;
    logic [LB_AW-1:0]  iss_idx_q, iss_idx_n;
    logic [RUN_W-1:0]  run_q, run_n;
    logic              bank_q, bank_n;
    logic              err_n;
    logic              req_n, we_n, ack_n;
    logic [MEM_AW-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic              do_write;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            rd_idx_q      <= '0;
            iss_idx_q     <= '0;
            run_q         <= '0;
            bank_q        <= 1'b0;
            fetch_err     <= 1'b0;
            fetch_busy    <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.wr_ack    <= 1'b0;
        end else begin
            state_q       <= state_n;
            base_q        <= base_n;
            rd_idx_q      <= rd_idx_n;
            iss_idx_q     <= iss_idx_n;
            run_q         <= run_n;
            bank_q        <= bank_n;
            fetch_err     <= err_n;
            fetch_busy    <= (state_n != ST_IDLE);
            bus.mem_req   <= req_n;
            bus.mem_we    <= we_n;
            bus.mem_addr  <= addr_n;
            bus.mem_wdata <= wdata_n;
            bus.wr_ack    <= ack_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        base_n    = base_q;
        rd_idx_n  = rd_idx_q;
        iss_idx_n = iss_idx_q;
        run_n     = run_q;
        bank_n    = bank_q;
        req_n     = 1'b0;
        we_n      = 1'b0;
        ack_n     = 1'b0;
        addr_n    = '0;
        wdata_n   = '0;
        do_write  = 1'b0;

        // overrun set takes precedence over a simultaneous clear
        err_n = err_clr ? 1'b0 : fetch_err;
        if (fetch_req && (state_q != ST_IDLE)) err_n = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                do_write = bus.wr_req;
                if (fetch_req) begin
                    state_n  = ST_FETCH;
                    base_n   = line_base(fetch_line);
                    bank_n   = fetch_line[0];
                    rd_idx_n = '0;
                    run_n    = '0;
                end
            end
            ST_FETCH: begin
                if ((run_q == RUN_MAX) && bus.wr_req) begin
                    do_write = 1'b1;
                    run_n    = '0;
                end else begin
                    req_n     = 1'b1;
                    addr_n    = base_q + MEM_AW'(rd_idx_q);
                    iss_idx_n = rd_idx_q;
                    rd_idx_n  = rd_idx_q + LB_AW'(1);
                    if (run_q != RUN_MAX) run_n = run_q + RUN_W'(1);
                    if (rd_idx_q == LAST_IDX) state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                do_write = bus.wr_req;
                if (fetch_done) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        if (do_write) begin
            req_n   = 1'b1;
            we_n    = 1'b1;
            ack_n   = 1'b1;
            addr_n  = bus.wr_addr;
            wdata_n = bus.wr_data;
        end
    end

    vga_rd_pipe #(.MEM_LAT(MEM_LAT)) u_rd_pipe (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .in_valid (bus.mem_req & ~bus.mem_we),
        .in_idx   (iss_idx_q),
        .in_last  (iss_idx_q == LAST_IDX),
        .lb_we    (bus.lb_we),
        .lb_addr  (bus.lb_addr),
        .done     (fetch_done)
    );

    assign bus.lb_bank  = bank_q;
    // memory data lands in the same cycle as the strobe, so it is passed through
    assign bus.lb_wdata = bus.lb_we ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: expected memory ops and line-buffer
// writes are queued by the stimulus and popped by an independent monitor.
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    logic       CLOCK_50 = 1'b0;
    logic       RESET = 1'b1;
    logic       fetch_req = 1'b0;
    logic       err_clr = 1'b0;
    logic [9:0] fetch_line = '0;
    logic       fetch_busy, fetch_done, fetch_err;

    vga_fb_arbiter_if bus ();

    vga_fb_arbiter #(.WORDS_PER_LINE(100), .MEM_LAT(2), .FAIR(8)) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .fetch_req  (fetch_req),
        .fetch_line (fetch_line),
        .err_clr    (err_clr),
        .fetch_busy (fetch_busy),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err),
        .bus        (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct { logic we; logic [15:0] addr; logic [23:0] wdata; } mem_exp_t;
    typedef struct { logic bank; logic [6:0] idx; logic [23:0] data; logic done; } lb_exp_t;
    typedef struct { logic [15:0] addr; logic [23:0] data; } wr_t;

    mem_exp_t mem_q [$];
    lb_exp_t  lb_q  [$];
    wr_t      wq    [$];
    int       ack_cyc [$];

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int rd_first = -1, rd_last = -1, done_cyc = -1, n_reads = 0;
    logic [15:0] last_rd_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model (data = 5A:addr, MEM_LAT=2) plus output monitor
    initial begin : monitor
        logic        h0v, h1v, iss;
        logic [15:0] h0a, h1a;
        mem_exp_t    me;
        lb_exp_t     le;
        h0v = 1'b0; h1v = 1'b0; h0a = '0; h1a = '0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge CLOCK_50);
            cyc++;
            #1;
            iss = bus.mem_req && !bus.mem_we;
            bus.mem_rdata = h1v ? {8'h5A, h1a} : 24'hBADBAD;
            h1v = h0v; h1a = h0a;
            h0v = iss; h0a = bus.mem_addr;
            #1;
            if (bus.mem_req) begin
                check("mem_expected", 64'(mem_q.size() != 0), 64'd1);
                if (mem_q.size() != 0) begin
                    me = mem_q.pop_front();
                    check("mem_op", 64'({bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 24'h0}),
                          64'({me.we, me.addr, me.we ? me.wdata : 24'h0}));
                end
                if (!bus.mem_we) begin
                    n_reads++;
                    if (rd_first < 0) rd_first = cyc;
                    rd_last = cyc;
                    last_rd_addr = bus.mem_addr;
                end
            end
            if (bus.wr_ack || (bus.mem_req && bus.mem_we)) begin
                check("wr_ack_vs_write", 64'(bus.wr_ack), 64'(bus.mem_req && bus.mem_we));
                if (bus.wr_ack) ack_cyc.push_back(cyc);
            end
            if (bus.lb_we) begin
                check("lb_expected", 64'(lb_q.size() != 0), 64'd1);
                if (lb_q.size() != 0) begin
                    le = lb_q.pop_front();
                    check("lb_write", 64'({bus.lb_bank, bus.lb_addr, bus.lb_wdata, fetch_done}),
                          64'({le.bank, le.idx, le.data, le.done}));
                end
                if (fetch_done) done_cyc = cyc;
            end else if (fetch_done) begin
                check("done_without_we", 64'(fetch_done), 64'd0);
            end
        end
    end

    // Drawing engine: holds the head write until it sees wr_ack
    initial begin : engine
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        forever begin
            @(posedge CLOCK_50);
            #3;
            if (bus.wr_ack && wq.size() != 0) void'(wq.pop_front());
            if (wq.size() != 0) begin
                bus.wr_req  = 1'b1;
                bus.wr_addr = wq[0].addr;
                bus.wr_data = wq[0].data;
            end else begin
                bus.wr_req = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors %0d miscompares", vecs, errs);
        $fatal(1, "watchdog");
    end

    task automatic clear_stats();
        rd_first = -1; rd_last = -1; done_cyc = -1; n_reads = 0;
        ack_cyc.delete();
    endtask

    // Expected sequence for one line: a write slot after every 8 reads while writes remain
    task automatic exp_fetch(input int line, input int nwr, input int wbase);
        int k = 0;
        for (int i = 0; i < 100; i++) begin
            if (i > 0 && (i % 8) == 0 && k < nwr) begin
                mem_q.push_back('{1'b1, 16'(wbase + k), 24'(24'hC00000 + k)});
                k++;
            end
            mem_q.push_back('{1'b0, 16'(line * 100 + i), 24'h0});
            lb_q.push_back('{1'(line % 2), 7'(i), {8'h5A, 16'(line * 100 + i)}, i == 99});
        end
    endtask

    task automatic start_fetch(input int line);
        @(negedge CLOCK_50);
        fetch_line = 10'(line);
        fetch_req  = 1'b1;
        @(negedge CLOCK_50);
        fetch_req  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((mem_q.size() != 0 || lb_q.size() != 0 || wq.size() != 0 || fetch_busy) && n < budget) begin
            @(negedge CLOCK_50);
            n++;
        end
        check(name, 64'(n < budget), 64'd1);
        repeat (4) @(negedge CLOCK_50);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, 64'({bus.mem_req, bus.mem_we, bus.wr_ack, bus.lb_we, fetch_busy, fetch_done, fetch_err}), 64'd0);
        check({tag, "_addr"}, 64'({bus.mem_addr, bus.lb_addr, bus.lb_bank}), 64'd0);
        check({tag, "_data"}, 64'({bus.mem_wdata, bus.lb_wdata}), 64'd0);
    endtask

    initial begin : stimulus
        int n;
        int base;

        repeat (3) @(negedge CLOCK_50);
        check_zero("in_reset");
        RESET = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        check_zero("after_reset");

        // line 5, no writes: 100 back-to-back reads from 500
        clear_stats();
        exp_fetch(5, 0, 0);
        start_fetch(5);
        wait_idle("t1_idle", 400);
        check("t1_read_span", 64'(rd_last - rd_first), 64'd99);
        check("t1_done_lat", 64'(done_cyc - rd_last), 64'd2);
        check("t1_reads", 64'(n_reads), 64'd100);

        // last line: top address without wrap
        clear_stats();
        exp_fetch(599, 0, 0);
        start_fetch(599);
        wait_idle("t2_idle", 400);
        check("t2_last_addr", 64'(last_rd_addr), 64'd59999);

        // line 0 with writes pending throughout: a slot after every 8 reads
        clear_stats();
        exp_fetch(0, 12, 1000);
        start_fetch(0);
        for (int k = 0; k < 12; k++) wq.push_back('{16'(1000 + k), 24'(24'hC00000 + k)});
        wait_idle("t3_idle", 400);
        check("t3_read_span", 64'(rd_last - rd_first), 64'd111);
        check("t3_acks", 64'(ack_cyc.size()), 64'd12);
        check("t3_done_lat", 64'(done_cyc - rd_last), 64'd2);

        // overrun in the middle of a fetch, clear, then overrun together with clear
        clear_stats();
        exp_fetch(3, 0, 0);
        start_fetch(3);
        repeat (48) @(negedge CLOCK_50);
        fetch_line = 10'd7; fetch_req = 1'b1;
        @(negedge CLOCK_50);
        fetch_req = 1'b0;
        @(negedge CLOCK_50);
        check("t4_err_set", 64'(fetch_err), 64'd1);
        err_clr = 1'b1;
        @(negedge CLOCK_50);
        err_clr = 1'b0;
        @(negedge CLOCK_50);
        check("t4_err_clr", 64'(fetch_err), 64'd0);
        fetch_line = 10'd8; fetch_req = 1'b1; err_clr = 1'b1;
        @(negedge CLOCK_50);
        fetch_req = 1'b0; err_clr = 1'b0;
        @(negedge CLOCK_50);
        check("t4_set_wins", 64'(fetch_err), 64'd1);
        wait_idle("t4_idle", 400);
        check("t4_err_sticky", 64'(fetch_err), 64'd1);
        err_clr = 1'b1;
        @(negedge CLOCK_50);
        err_clr = 1'b0;
        @(negedge CLOCK_50);
        check("t4_err_clr2", 64'(fetch_err), 64'd0);

        // fetch_req in the cycle fetch_done pulses is an overrun
        clear_stats();
        exp_fetch(4, 0, 0);
        start_fetch(4);
        n = 0;
        while (!fetch_done && n < 300) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("t5_done_seen", 64'(fetch_done), 64'd1);
        fetch_line = 10'd9; fetch_req = 1'b1;
        @(negedge CLOCK_50);
        fetch_req = 1'b0;
        check("t5_err", 64'(fetch_err), 64'd1);
        check("t5_not_busy", 64'(fetch_busy), 64'd0);
        wait_idle("t5_idle", 100);
        err_clr = 1'b1;
        @(negedge CLOCK_50);
        err_clr = 1'b0;

        // reset while read 40 of line 1 is on the bus
        clear_stats();
        exp_fetch(1, 0, 0);
        start_fetch(1);
        base = n_reads;
        n = 0;
        while ((n_reads - base) < 41 && n < 300) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("t6_reached_read40", 64'(last_rd_addr), 64'd140);
        RESET = 1'b1;
        #1;
        check_zero("mid_reset");
        mem_q.delete();
        lb_q.delete();
        @(negedge CLOCK_50);
        RESET = 1'b0;
        repeat (20) @(negedge CLOCK_50);
        check("t6_idle_after_reset", 64'({fetch_busy, bus.lb_we}), 64'd0);

        // clean fetch of line 2 after the reset
        clear_stats();
        exp_fetch(2, 0, 0);
        start_fetch(2);
        wait_idle("t7_idle", 400);
        check("t7_reads", 64'(n_reads), 64'd100);

        // idle: three back-to-back writes
        clear_stats();
        mem_q.push_back('{1'b1, 16'd10, 24'h123456});
        mem_q.push_back('{1'b1, 16'd11, 24'hABCDEF});
        mem_q.push_back('{1'b1, 16'd12, 24'h0F0F0F});
        wq.push_back('{16'd10, 24'h123456});
        wq.push_back('{16'd11, 24'hABCDEF});
        wq.push_back('{16'd12, 24'h0F0F0F});
        wait_idle("t8_idle", 50);
        check("t8_acks", 64'(ack_cyc.size()), 64'd3);
        if (ack_cyc.size() == 3) begin
            check("t8_ack_gap01", 64'(ack_cyc[1] - ack_cyc[0]), 64'd1);
            check("t8_ack_gap12", 64'(ack_cyc[2] - ack_cyc[1]), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter WORDS_PER_LINE, 100, 24-bit words per 800-pixel line (8 pixels x 3-bit RGB per word).
REQ-002 Parameter MEM_LAT, 2, fixed read latency of the shared memory in cycles.
REQ-003 Parameter FAIR, 8, maximum consecutive fetch reads before one pending write is granted a slot.
REQ-004 CLOCK_50  in  1  system/pixel clock, 50 MHz; all logic on its rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 fetch_req  in  1  one-cycle pulse from the timing generator: prefetch line fetch_line.
REQ-007 fetch_line  in  10  line number 0..599; sampled only when fetch_req=1.
REQ-008 err_clr  in  1  one-cycle pulse; clears fetch_err.
REQ-009 wr_req  in  1  drawing-engine write request; held with wr_addr/wr_data until wr_ack.
REQ-010 wr_addr  in  16  write word address 0..59999.
REQ-011 wr_data  in  24  write data.
REQ-012 wr_ack  out  1  one-cycle pulse in the cycle the write is issued to memory.
REQ-013 mem_req  out  1  memory access issued this cycle (memory accepts every cycle).
REQ-014 mem_we  out  1  1=write, 0=read; valid when mem_req=1.
REQ-015 mem_addr  out  16  memory word address.
REQ-016 mem_wdata  out  24  write data (equal to wr_data when mem_we=1).
REQ-017 mem_rdata  in  24  read data, valid exactly MEM_LAT cycles after a read issue.
REQ-018 lb_we  out  1  line-buffer write strobe.
REQ-019 lb_bank  out  1  ping-pong bank = bit 0 of the line being fetched.
REQ-020 lb_addr  out  7  word index 0..WORDS_PER_LINE-1.
REQ-021 lb_wdata  out  24  line-buffer write data.
REQ-022 fetch_busy  out  1  high while in FETCH or DRAIN.
REQ-023 fetch_done  out  1  one-cycle pulse in the cycle the last word is written to the line buffer.
REQ-024 fetch_err  out  1  sticky overrun flag.

Function
REQ-025 States IDLE, FETCH, DRAIN; IDLE->FETCH on fetch_req; FETCH->DRAIN after read WORDS_PER_LINE-1 is issued; DRAIN->IDLE in the cycle fetch_done pulses.
REQ-026 On fetch_req in IDLE, base = fetch_line*100 computed as (line<<6)+(line<<5)+(line<<2) in 16 bits; lb_bank latched from fetch_line[0].
REQ-027 In FETCH, read i (0..99) is issued with mem_addr=base+i; issued reads are consecutive except for granted fairness slots.
REQ-028 Arbitration: fetch reads have priority; after FAIR consecutive reads, if wr_req=1, the next cycle issues the write (wr_ack=1) and the run counter resets; if wr_req=0, reads continue and the counter holds at FAIR.
REQ-029 In IDLE and DRAIN, a pending wr_req is issued in the next cycle, one write per cycle; back-to-back writes are allowed.
REQ-030 Each read result appears on lb_we/lb_addr/lb_wdata exactly MEM_LAT cycles after issue; lb_addr equals that read's index i.
REQ-031 A fetch_req while fetch_busy=1 is ignored and sets fetch_err; fetch_err clears only on err_clr or RESET; if err_clr and an overrun occur in the same cycle, set wins.
REQ-032 wr_ack never pulses in a cycle in which a read is issued; at most one mem_req per cycle.
REQ-033 fetch_req in the cycle DRAIN->IDLE is treated as overrun (busy still 1).

Reset
REQ-034 RESET asynchronously forces state IDLE; all counters to 0; mem_req, mem_we, wr_ack, lb_we, fetch_busy, fetch_done, fetch_err to 0; mem_addr, mem_wdata, lb_addr, lb_wdata, lb_bank to 0.
REQ-035 Reset mid-fetch discards in-flight reads; no lb_we occurs after RESET deasserts until a new fetch is issued.

Structure
REQ-036 Package vga_pkg holds H/V timing constants (800/56/120/64, 600/37/6/23), WORDS_PER_LINE, address widths and the state encoding.
REQ-037 One sub-module, vga_rd_pipe: MEM_LAT-deep valid/index shift register that generates lb_we/lb_addr.

Verification
REQ-038 fetch_req with fetch_line=5, wr_req=0 -> reads at addr 500..599 on 100 consecutive cycles; lb_we for indices 0..99; lb_bank=1; fetch_done 2 cycles after last read.
REQ-039 fetch_line=599 -> last mem_addr=59999, no 16-bit overflow.
REQ-040 wr_req held throughout fetch of line 0 -> wr_ack after reads 8, 16, ..., each followed by the next read; 100 lb_we total.
REQ-041 Second fetch_req 50 cycles into fetch -> ignored, fetch_err=1 until err_clr; first fetch completes normally.
REQ-042 RESET asserted at read index 40 -> all outputs 0 immediately; no lb_we after release; next fetch of line 2 completes with indices 0..99.
REQ-043 Idle, 3 back-to-back writes to addr 10,11,12 -> wr_ack on 3 consecutive cycles, mem_we=1, matching data.
